// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package piso_pkg;

  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Bits needed to index 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    int unsigned rem;
    bits = 0;
    rem  = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clears on a word accept,
// advances while enabled and holds once it reaches the terminal count.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned W  = DEFAULT_W,
  parameter int unsigned CW = clog2(W)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(W - 1));

  // Count bit positions; wrap to zero only through an explicit clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter feeding the serial delay chain.
// Accepts a W-bit word on valid/ready and emits one bit per clk with
// frame_start/frame_done markers; back-to-back words leave no gap.
// Optional macro PISO_PARITY_EN appends an even-parity bit per word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned W          = DEFAULT_W,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         frame_done,
  output logic         busy
);

  localparam int unsigned CW = clog2(W);

  state_t        state;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          accept;
  logic          pre_last;
  logic          first_bit;
  logic          next_bit;
  logic [W-1:0]  shifted;
`ifdef PISO_PARITY_EN
  logic          par;
`endif

  assign accept    = load_valid & load_ready;
  assign pre_last  = (cnt == CW'(W - 2));
  assign first_bit = MSB_FIRST ? load_data[W-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? sreg[W-2] : sreg[1];
  assign shifted   = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

  piso_bit_counter #(
    .W  (W),
    .CW (CW)
  ) u_bit_counter (
    .clk    (clk),
    .clr    (clr),
    .clear  (accept),
    .enable (state == SHIFT),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Frame FSM; every output is a flop loaded with its next-cycle value,
  // so load_ready/frame_done are raised one edge ahead of the last bit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      sreg        <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= 1'b0;
`endif
    end else if (accept) begin
      state       <= SHIFT;
      sreg        <= load_data;
      ser_out     <= first_bit;
      ser_valid   <= 1'b1;
      frame_start <= 1'b1;
      frame_done  <= 1'b0;
      busy        <= 1'b1;
      load_ready  <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= ^load_data;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        SHIFT: begin
          if (!tc) begin
            sreg      <= shifted;
            ser_out   <= next_bit;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef PISO_PARITY_EN
            frame_done <= 1'b0;
            load_ready <= 1'b0;
`else
            frame_done <= pre_last;
            load_ready <= pre_last;
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state      <= PARITY;
            ser_out    <= par;
            ser_valid  <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b1;
            load_ready <= 1'b1;
`else
            state      <= IDLE;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
`endif
          end
        end
        default: begin
          state      <= IDLE;
          ser_out    <= IDLE_LEVEL;
          ser_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
